ahb_lite_master: RTL and testbench

Core-side AHB-Lite initiator: converts a valid/ready request stream from the RISC-V core's fetch or load/store unit into AHB-Lite transfers on the system bus (ROM, RAM, peripherals) and returns read data and status on a response stream. It overlaps one transfer's address phase with the previous transfer's data phase. There is at most one transfer in each phase. Only single NONSEQ transfers are issued; bursts are not generated.

---
 rtl/ahb_pkg.sv | 34 +++
 rtl/ahb_lite_master_if.sv | 47 ++++
 rtl/ahb_align_chk.sv | 22 ++
 rtl/ahb_lite_master.sv | 159 +++++++++++++++
 tb/tb_ahb_lite_master.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the core-side initiator: bus encodings,
// data-path widths and the request record carried through the address stage.
package ahb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // One core request as it sits in the address stage.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [2:0]        size;
        logic [DATA_W-1:0] wdata;
    } ahb_req_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// Bundle of the core request/response streams and the AHB-Lite master
// signals. The master modport is the initiator's view; the slave modport is
// the view of whatever sits on the other side (core + bus fabric).
interface ahb_lite_master_if;
    import ahb_pkg::*;

    // Core request stream
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [2:0]        req_size;
    logic [DATA_W-1:0] req_wdata;

    // Core response stream
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // AHB-Lite bus
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic [1:0]        HRESP;

    modport master (
        input  req_valid, req_addr, req_write, req_size, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output req_valid, req_addr, req_write, req_size, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HREADY, HRESP
    );

endinterface

// File: rtl/ahb_align_chk.sv
// Size/address legality check for an incoming request. Flags halfwords on an
// odd address, words not on a 4-byte boundary, and any size above a word.
module ahb_align_chk
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    // Decode legality from the transfer size and the low address bits
    always_comb begin
        misaligned = 1'b1;
        case (size)
            HSIZE_BYTE: misaligned = 1'b0;
            HSIZE_HALF: misaligned = addr_lo[0];
            HSIZE_WORD: misaligned = (addr_lo != 2'b00);
            default:    misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Core-side AHB-Lite initiator. Requests enter an address stage (A) that
// drives HADDR/HTRANS/HWRITE/HSIZE, then move to a data stage (D) that drives
// HWDATA and completes on HREADY, producing a one-cycle response pulse.
// Address and data phases of consecutive transfers overlap; only SINGLE
// NONSEQ transfers are issued.
//
// Misaligned requests travel through A and D as "phantom" slots that never
// appear on the bus (HTRANS stays IDLE) and complete with rsp_err=1, which
// keeps responses strictly in request order.
//
// Optional feature macro: AHB_MASTER_ERR_EN
//   defined   - two-cycle ERROR responses are honoured: the address phase
//               pending behind the failing transfer is cancelled (HTRANS=IDLE
//               in the second error cycle) and re-issued afterwards, and the
//               failing transfer completes with rsp_err=1.
//   undefined - HRESP is ignored; rsp_err reports misalignment only.
module ahb_lite_master
    import ahb_pkg::*;
(
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_lite_master_if.master bus
);

    // Address stage
    ahb_req_t          a_req_reg;
    logic              a_valid_reg;
    logic              a_phantom_reg;

    // Data stage
    logic              d_valid_reg;
    logic              d_phantom_reg;
    logic              d_write_reg;
    logic [DATA_W-1:0] d_wdata_reg;

    // Response registers
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;

    ahb_req_t          req;
    logic              req_misaligned;
    logic              req_ready;
    logic              accept;
    logic              d_done;
    logic              cancel;
    logic              resp_error;

    assign req = '{
        addr:  bus.req_addr,
        write: bus.req_write,
        size:  bus.req_size,
        wdata: bus.req_wdata
    };

    ahb_align_chk u_align_chk (
        .size       (bus.req_size),
        .addr_lo    (bus.req_addr[1:0]),
        .misaligned (req_misaligned)
    );

`ifdef AHB_MASTER_ERR_EN
    // Set during the second cycle of a two-cycle ERROR response; while set,
    // the address stage is shown as IDLE and must not advance into D.
    logic cancel_reg;

    assign cancel     = cancel_reg;
    assign resp_error = (bus.HRESP == HRESP_ERROR);

    // Detect the first ERROR cycle (HREADY low) on a real data phase
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cancel_reg <= 1'b0;
        end else if (bus.HREADY) begin
            cancel_reg <= 1'b0;
        end else if (d_valid_reg && !d_phantom_reg && resp_error) begin
            cancel_reg <= 1'b1;
        end
    end
`else
    logic unused_hresp;

    assign cancel       = 1'b0;
    assign resp_error   = 1'b0;
    assign unused_hresp = ^bus.HRESP;
`endif

    // A can take a request when it is empty or is handing its content to D
    // this edge. A cancelled address phase stays in A, so it blocks intake.
    assign req_ready = !a_valid_reg || (bus.HREADY && !cancel);
    assign accept    = bus.req_valid && req_ready;
    assign d_done    = d_valid_reg && bus.HREADY;

    // Advance the A and D pipeline stages
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_req_reg     <= '0;
            a_valid_reg   <= 1'b0;
            a_phantom_reg <= 1'b0;
            d_valid_reg   <= 1'b0;
            d_phantom_reg <= 1'b0;
            d_write_reg   <= 1'b0;
            d_wdata_reg   <= '0;
        end else begin
            if (accept) begin
                a_req_reg     <= req;
                a_valid_reg   <= 1'b1;
                a_phantom_reg <= req_misaligned;
            end else if (bus.HREADY && !cancel) begin
                a_valid_reg   <= 1'b0;
            end

            if (bus.HREADY) begin
                if (cancel) begin
                    // The pending address phase was never seen by a slave;
                    // it stays in A and is re-issued next cycle.
                    d_valid_reg <= 1'b0;
                end else begin
                    d_valid_reg <= a_valid_reg;
                    if (a_valid_reg) begin
                        d_phantom_reg <= a_phantom_reg;
                        d_write_reg   <= a_req_reg.write;
                        d_wdata_reg   <= a_req_reg.wdata;
                    end
                end
            end
        end
    end

    // Register the response when the data stage completes
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else if (d_done) begin
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= (d_write_reg || d_phantom_reg) ? '0 : bus.HRDATA;
            rsp_err_reg   <= d_phantom_reg || resp_error;
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

    assign bus.HTRANS = (a_valid_reg && !a_phantom_reg && !cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HADDR  = a_req_reg.addr;
    assign bus.HWRITE = a_req_reg.write;
    assign bus.HSIZE  = a_req_reg.size;
    assign bus.HBURST = HBURST_SINGLE;
    assign bus.HWDATA = d_wdata_reg;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: a small slave model answers reads,
// expected responses are queued when requests are driven and compared when
// rsp_valid pulses; bus-side timing is checked step by step.
`timescale 1ns/1ps
module tb_ahb_lite_master;
    import ahb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ahb_lite_master_if bus ();

    ahb_lite_master dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   rsp_count = 0;
    int   pushed    = 0;

    logic [31:0] mis_addr [5] = '{32'h3, 32'h5, 32'h2, 32'h0, 32'h6};
    logic [2:0]  mis_size [5] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd1};

    // Slave data returned for a read of address a
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic mis(input logic [2:0] s, input logic [31:0] a);
        case (s)
            3'd0:    return 1'b0;
            3'd1:    return a[0];
            3'd2:    return (a[1:0] != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

    // Slave model: remembers the accepted address phase, returns data in the data phase
    logic        dp_valid;
    logic [31:0] dp_addr;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid <= 1'b0;
            dp_addr  <= '0;
        end else if (bus.HREADY) begin
            dp_valid <= (bus.HTRANS == 2'b10);
            dp_addr  <= bus.HADDR;
        end
    end
    assign bus.HRDATA = dp_valid ? rd_fn(dp_addr) : 32'hBAD0_0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] a, input logic w, input logic [2:0] s,
                             input logic [31:0] d, input logic do_push, input logic force_err);
        exp_t x;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.req_size  = s;
        bus.req_wdata = d;
        if (do_push) begin
            x.rdata = (w || mis(s, a)) ? 32'h0 : rd_fn(a);
            x.err   = mis(s, a) || force_err;
            exp_q.push_back(x);
            pushed++;
        end
    endtask

    task automatic idle_req();
        bus.req_valid = 1'b0;
    endtask

    // Response scoreboard
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            rsp_count++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL rsp_unexpected: observed rdata=%h err=%b expected=no response",
                       bus.rsp_rdata, bus.rsp_err);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
            end
            $display("rsp %0d: rdata=%h err=%b", rsp_count, bus.rsp_rdata, bus.rsp_err);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        bus.req_size  = 3'd0;
        bus.req_wdata = '0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = HRESP_OKAY;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
        chk("rst_hsize", 32'(bus.HSIZE), 32'h0);
        chk("rst_hburst", 32'(bus.HBURST), 32'h0);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        rst = 1'b0;
        step();

        // Single zero-wait read of 0x10
        drive_req(32'h10, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rd_ready", 32'(bus.req_ready), 32'h1);
        step();
        idle_req();
        @(negedge clk);
        chk("rd_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        chk("rd_haddr", bus.HADDR, 32'h10);
        chk("rd_hwrite", 32'(bus.HWRITE), 32'h0);
        chk("rd_hsize", 32'(bus.HSIZE), 32'(HSIZE_WORD));
        chk("rd_rsp_early", 32'(bus.rsp_valid), 32'h0);
        step();
        @(negedge clk);
        chk("rd_htrans_idle", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk("rd_rsp_early2", 32'(bus.rsp_valid), 32'h0);
        step();
        @(negedge clk);
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        step();
        @(negedge clk);
        chk("rd_rsp_once", 32'(bus.rsp_valid), 32'h0);
        step();

        // Four back-to-back zero-wait word reads
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive_req(32'(i * 4), 1'b0, HSIZE_WORD, 32'h0, 1'b1, 1'b0);
            else idle_req();
            @(negedge clk);
            if (i < 4) chk("b2b_ready", 32'(bus.req_ready), 32'h1);
            if (i >= 1 && i <= 4) begin
                chk("b2b_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
                chk("b2b_haddr", bus.HADDR, 32'((i - 1) * 4));
            end
            if (i == 5) chk("b2b_htrans_idle", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
            if (i >= 3) chk("b2b_rsp_valid", 32'(bus.rsp_valid), (i <= 6) ? 32'h1 : 32'h0);
            step();
        end

        // Write with two wait states in the data phase
        drive_req(32'h20, 1'b1, HSIZE_WORD, 32'h1234_5678, 1'b1, 1'b0);
        @(negedge clk);
        chk("wr_ready", 32'(bus.req_ready), 32'h1);
        step();
        idle_req();
        @(negedge clk);
        chk("wr_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        chk("wr_haddr", bus.HADDR, 32'h20);
        chk("wr_hwrite", 32'(bus.HWRITE), 32'h1);
        step();
        for (int i = 0; i < 3; i++) begin
            bus.HREADY = (i == 2);
            @(negedge clk);
            chk("wr_hwdata", bus.HWDATA, 32'h1234_5678);
            chk("wr_no_rsp", 32'(bus.rsp_valid), 32'h0);
            step();
        end
        @(negedge clk);
        chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        step();
        @(negedge clk);
        chk("wr_rsp_once", 32'(bus.rsp_valid), 32'h0);
        step();

        // Misaligned requests interleaved with legal ones
        for (int i = 0; i < 9; i++) begin
            if (i < 5) drive_req(mis_addr[i], 1'b0, mis_size[i], 32'h0, 1'b1, 1'b0);
            else idle_req();
            @(negedge clk);
            if (i >= 1 && i <= 5)
                chk("mis_htrans", 32'(bus.HTRANS),
                    mis(mis_size[i-1], mis_addr[i-1]) ? 32'(HTRANS_IDLE) : 32'(HTRANS_NONSEQ));
            if (i >= 3) chk("mis_rsp_valid", 32'(bus.rsp_valid), (i <= 7) ? 32'h1 : 32'h0);
            step();
        end

`ifdef AHB_MASTER_ERR_EN
        // ERROR response on a read with a queued read behind it
        drive_req(32'h40, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 1'b1);
        @(negedge clk);
        chk("err_ready0", 32'(bus.req_ready), 32'h1);
        step();
        drive_req(32'h44, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("err_htrans0", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        chk("err_haddr0", bus.HADDR, 32'h40);
        chk("err_ready1", 32'(bus.req_ready), 32'h1);
        step();
        idle_req();
        bus.HREADY = 1'b0;
        bus.HRESP  = HRESP_ERROR;
        @(negedge clk);
        chk("err_htrans1", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        chk("err_haddr1", bus.HADDR, 32'h44);
        chk("err_ready_wait", 32'(bus.req_ready), 32'h0);
        step();
        bus.HREADY = 1'b1;
        @(negedge clk);
        chk("err_htrans_cancel", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk("err_rsp_early", 32'(bus.rsp_valid), 32'h0);
        step();
        bus.HRESP = HRESP_OKAY;
        @(negedge clk);
        chk("err_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("err_reissue_htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        chk("err_reissue_haddr", bus.HADDR, 32'h44);
        step();
        @(negedge clk);
        chk("err_gap", 32'(bus.rsp_valid), 32'h0);
        chk("err_htrans_done", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        step();
        @(negedge clk);
        chk("err_rsp2_valid", 32'(bus.rsp_valid), 32'h1);
        step();
        @(negedge clk);
        chk("err_rsp2_once", 32'(bus.rsp_valid), 32'h0);
        step();
`endif

        // Reset pulsed while a data phase is stalled
        drive_req(32'h80, 1'b0, HSIZE_WORD, 32'h0, 1'b0, 1'b0);
        step();
        idle_req();
        @(negedge clk);
        chk("rst_mid_htrans0", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        step();
        bus.HREADY = 1'b0;
        drive_req(32'h84, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'h1);
        step();
        idle_req();
        @(negedge clk);
        chk("rst_mid_htrans1", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        chk("rst_mid_haddr1", bus.HADDR, 32'h84);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk("rst_mid_haddr", bus.HADDR, 32'h0);
        chk("rst_mid_hwrite", 32'(bus.HWRITE), 32'h0);
        chk("rst_mid_hsize", 32'(bus.HSIZE), 32'h0);
        chk("rst_mid_hwdata", bus.HWDATA, 32'h0);
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        step();
        rst = 1'b0;
        bus.HREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_no_rsp", 32'(bus.rsp_valid), 32'h0);
            chk("rst_mid_idle", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
            step();
        end

        // Recovery read after reset
        for (int i = 0; i < 5; i++) begin
            if (i == 0) drive_req(32'h0C, 1'b0, HSIZE_WORD, 32'h0, 1'b1, 1'b0);
            else idle_req();
            @(negedge clk);
            chk("post_rst_rsp", 32'(bus.rsp_valid), (i == 3) ? 32'h1 : 32'h0);
            step();
        end

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        chk("rsp_count", 32'(rsp_count), 32'(pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
